bus_stream_port: RTL and testbench

Memory-mapped responder on the CPU's asynchronous-style memory bus (a, d, n_oe, n_we, n_rdy). It is the target side of the transactions the CPU initiates. It bridges the bus to two byte streams through two small FIFOs:
- An external in-stream, which the CPU reads.
- An external out-stream, which the CPU writes.

It also inserts a programmable number of wait states via n_rdy. It sits beside RAM on the shared bus and claims a two-byte window.

---
 rtl/bus_stream_port_pkg.sv | 37 +++
 rtl/bus_stream_port_fifo.sv | 49 ++++
 rtl/bus_stream_port.sv | 162 ++++++++++++++++
 tb/tb_bus_stream_port.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_stream_port_pkg.sv
// Shared definitions for bus_stream_port: register offsets, STATUS layout,
// access state encoding and the STATUS byte builder.
package bus_stream_port_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;

  // Offsets inside the two-byte window
  localparam logic DATA_OFF   = 1'b0;
  localparam logic STATUS_OFF = 1'b1;

  // STATUS bit positions; bits 7:4 read as zero
  localparam int unsigned ST_IN_NEMPTY = 0;
  localparam int unsigned ST_OUT_NFULL = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_UNDERFLOW = 3;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_state_e;

  function automatic logic [BYTE_W-1:0] make_status(input logic in_nempty,
                                                    input logic out_nfull,
                                                    input logic overflow,
                                                    input logic underflow);
    logic [BYTE_W-1:0] s;
    s = '0;
    s[ST_IN_NEMPTY] = in_nempty;
    s[ST_OUT_NFULL] = out_nfull;
    s[ST_OVERFLOW]  = overflow;
    s[ST_UNDERFLOW] = underflow;
    return s;
  endfunction

endpackage

// File: rtl/bus_stream_port_fifo.sv
// bus_port_fifo: small synchronous byte FIFO with wrap-bit pointers.
// Ports: clk, n_rst (async active-low), push/wdata, pop/rdata (head, shown
// combinationally), full, empty. Push when full and pop when empty are ignored;
// both flags come from pre-edge pointer state.
module bus_port_fifo
  import bus_stream_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic              w_push;
  logic              w_pop;

  // Same index with differing wrap bit means full
  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/bus_stream_port.sv
// bus_stream_port: memory-mapped responder bridging the CPU bus to two byte
// streams. DATA (offset 0) reads pop the in-stream FIFO, writes push the
// out-stream FIFO; STATUS (offset 1) reports FIFO state and sticky error
// flags, and a write to it clears the flags. n_rdy inserts WAIT_STATES stalls.
// Ports: clk, n_rst, a, d (tristate), n_oe, n_we, n_rdy,
//        in_data/in_valid/in_ready, out_data/out_valid/out_ready.
module bus_stream_port
  import bus_stream_port_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'hC000,
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] a,
  inout  wire  [BYTE_W-1:0] d,
  input  logic              n_oe,
  input  logic              n_we,
  output logic              n_rdy,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_STATES);

  acc_state_e        r_state;
  logic              r_oe_prev;
  logic              r_we_prev;
  logic              r_off;
  logic              r_overflow;
  logic              r_underflow;
  logic [BYTE_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_sel;
  logic              w_start;
  logic              w_access;
  logic              w_rd_end;
  logic              w_wr_end;
  logic              w_drive;
  logic              w_in_full;
  logic              w_in_empty;
  logic              w_out_full;
  logic              w_out_empty;
  logic              w_in_pop;
  logic              w_out_push;
  logic [BYTE_W-1:0] w_in_head;
  logic [BYTE_W-1:0] w_status;
  logic [BYTE_W-1:0] w_rdata;

  assign w_sel = (a[ADDR_W-1:1] == BASE_ADDR[ADDR_W-1:1]);

  // Start needs a high-to-low strobe transition; prev regs reset low so a
  // strobe held low through reset is ignored until it returns high
  assign w_start  = (r_state == ACC_IDLE) & w_sel &
                    ((~n_oe & r_oe_prev) | (~n_we & r_we_prev));
  assign w_access = w_start | ((r_state == ACC_READ) & ~n_oe) |
                    ((r_state == ACC_WRITE) & ~n_we);
  assign w_rd_end = (r_state == ACC_READ) & n_oe;
  assign w_wr_end = (r_state == ACC_WRITE) & n_we;

  assign n_rdy = w_access & w_sel & (r_cnt < CNT_MAX);

  assign w_in_pop   = w_rd_end & (r_off == DATA_OFF) & ~w_in_empty;
  assign w_out_push = w_wr_end & (r_off == DATA_OFF) & ~w_out_full;

  assign in_ready  = ~w_in_full;
  assign out_valid = ~w_out_empty;

  // Read mux: empty DATA reads as zero
  assign w_status = make_status(~w_in_empty, ~w_out_full, r_overflow, r_underflow);
  assign w_rdata  = (r_off == STATUS_OFF) ? w_status :
                    (w_in_empty ? '0 : w_in_head);
  assign w_drive  = ~n_oe & w_sel & n_we & (r_state == ACC_READ);
  assign d        = w_drive ? w_rdata : 'z;

  bus_port_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (w_in_pop),
    .rdata (w_in_head),
    .full  (w_in_full),
    .empty (w_in_empty)
  );

  bus_port_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (w_out_push),
    .wdata (r_wdata),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (w_out_full),
    .empty (w_out_empty)
  );

  // Access FSM, strobe history, wait counter and sticky flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ACC_IDLE;
      r_oe_prev   <= 1'b0;
      r_we_prev   <= 1'b0;
      r_off       <= DATA_OFF;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
    end else begin
      r_oe_prev <= n_oe;
      r_we_prev <= n_we;

      if (w_access) begin
        if (r_cnt < CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end

      case (r_state)
        ACC_IDLE: begin
          if (w_start) begin
            r_off <= a[0];
            if (!n_we) begin
              r_state <= ACC_WRITE;
              r_wdata <= d;
            end else begin
              r_state <= ACC_READ;
            end
          end
        end
        ACC_READ: begin
          if (n_oe) begin
            r_state <= ACC_IDLE;
            if ((r_off == DATA_OFF) && w_in_empty) r_underflow <= 1'b1;
          end
        end
        ACC_WRITE: begin
          if (n_we) begin
            r_state <= ACC_IDLE;
            if (r_off == DATA_OFF) begin
              if (w_out_full) r_overflow <= 1'b1;
            end else begin
              r_overflow  <= 1'b0;
              r_underflow <= 1'b0;
            end
          end else begin
            r_wdata <= d;
          end
        end
        default: r_state <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_stream_port.sv
// Self-checking bench for bus_stream_port: directed vector table plus
// hand-written sequences for reset, underflow, same-edge drop, wait states,
// pointer wrap and simultaneous push/pop. Undriven d reads 8'hFF via pullup.
module tb_bus_stream_port;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WS    = 3;
  localparam int          TMO   = 20;
  localparam logic [15:0] A_DATA = 16'hC000;
  localparam logic [15:0] A_STAT = 16'hC001;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] a;
  wire  [7:0]  d;
  logic        n_oe;
  logic        n_we;
  logic        n_rdy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        tb_drv;
  logic [7:0]  tb_d;

  int n_pass  = 0;
  int n_total = 0;

  assign d = tb_drv ? tb_d : 8'hzz;
  pullup (d);

  always #5 clk = ~clk;

  bus_stream_port #(
    .BASE_ADDR   (16'hC000),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .a         (a),
    .d         (d),
    .n_oe      (n_oe),
    .n_we      (n_we),
    .n_rdy     (n_rdy),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef enum int {OP_PUSH, OP_RD, OP_WR, OP_OUT, OP_NOOUT, OP_INFULL} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] addr;
    logic [7:0]  data;   // pushed/written byte, or expected read/out byte
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bus tasks start and end one time unit after a rising edge
  task automatic bus_read(input logic [15:0] addr, input logic side_push,
                          input logic [7:0] side_data, output logic [7:0] rd,
                          output int waits);
    a     = addr;
    n_oe  = 1'b0;
    waits = 0;
    @(negedge clk);
    while (n_rdy && waits < TMO) begin
      @(negedge clk);
      waits++;
    end
    check("rd_nrdy_bound", 8'(waits < TMO), 8'h01);
    rd = d;
    @(posedge clk); #1;
    n_oe = 1'b1;
    if (side_push) begin
      in_data  = side_data;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                           input logic side_ready);
    int waits;
    a      = addr;
    tb_d   = data;
    tb_drv = 1'b1;
    n_we   = 1'b0;
    waits  = 0;
    @(negedge clk);
    while (n_rdy && waits < TMO) begin
      @(negedge clk);
      waits++;
    end
    check("wr_nrdy_bound", 8'(waits < TMO), 8'h01);
    @(posedge clk); #1;
    n_we   = 1'b1;
    tb_drv = 1'b0;
    if (side_ready) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic push_in(input logic [7:0] data);
    check("push_in_ready", 8'(in_ready), 8'h01);
    in_data  = data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take_out(input logic [7:0] exp);
    @(negedge clk);
    check("out_valid", 8'(out_valid), 8'h01);
    check("out_data", out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] rd;
    int         waits;

    n_rst     = 1'b0;
    a         = A_DATA;
    n_oe      = 1'b0;
    n_we      = 1'b1;
    tb_drv    = 1'b0;
    tb_d      = 8'h00;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset held with a read strobe low on the window
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_d_hiz", d, 8'hFF);
    check("rst_n_rdy", 8'(n_rdy), 8'h00);
    check("rst_in_ready", 8'(in_ready), 8'h01);
    check("rst_out_valid", 8'(out_valid), 8'h00);
    check("rst_out_data", out_data, 8'h00);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Strobe still low after release: no access, so 8'h5A must survive
    push_in(8'h5A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_n_rdy", 8'(n_rdy), 8'h00);
      check("post_rst_d_hiz", d, 8'hFF);
    end
    @(posedge clk); #1;
    n_oe = 1'b1;
    @(posedge clk); #1;
    bus_read(A_DATA, 1'b0, 8'h00, rd, waits);
    check("post_rst_no_pop", rd, 8'h5A);

    // Directed vector table
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h11});
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h22});
    vecs.push_back('{OP_RD,    A_STAT,   8'h03});
    vecs.push_back('{OP_RD,    A_DATA,   8'h11});
    vecs.push_back('{OP_RD,    A_DATA,   8'h22});
    vecs.push_back('{OP_RD,    A_STAT,   8'h02});
    vecs.push_back('{OP_WR,    A_DATA,   8'hA0});
    vecs.push_back('{OP_WR,    A_DATA,   8'hA1});
    vecs.push_back('{OP_WR,    A_DATA,   8'hA2});
    vecs.push_back('{OP_WR,    A_DATA,   8'hA3});
    vecs.push_back('{OP_WR,    A_DATA,   8'hA4});
    vecs.push_back('{OP_RD,    A_STAT,   8'h04});
    vecs.push_back('{OP_OUT,   16'h0000, 8'hA0});
    vecs.push_back('{OP_OUT,   16'h0000, 8'hA1});
    vecs.push_back('{OP_OUT,   16'h0000, 8'hA2});
    vecs.push_back('{OP_OUT,   16'h0000, 8'hA3});
    vecs.push_back('{OP_NOOUT, 16'h0000, 8'h00});
    vecs.push_back('{OP_WR,    A_STAT,   8'h00});
    vecs.push_back('{OP_RD,    A_STAT,   8'h02});
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h71});
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h72});
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h73});
    vecs.push_back('{OP_PUSH,  16'h0000, 8'h74});
    vecs.push_back('{OP_INFULL,16'h0000, 8'h00});
    vecs.push_back('{OP_RD,    A_STAT,   8'h03});
    vecs.push_back('{OP_RD,    A_DATA,   8'h71});
    vecs.push_back('{OP_RD,    A_DATA,   8'h72});
    vecs.push_back('{OP_RD,    A_DATA,   8'h73});
    vecs.push_back('{OP_RD,    A_DATA,   8'h74});
    vecs.push_back('{OP_RD,    A_STAT,   8'h02});

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_PUSH: push_in(vecs[i].data);
        OP_RD: begin
          bus_read(vecs[i].addr, 1'b0, 8'h00, rd, waits);
          check($sformatf("vec%0d_rd", i), rd, vecs[i].data);
        end
        OP_WR:  bus_write(vecs[i].addr, vecs[i].data, 1'b0);
        OP_OUT: take_out(vecs[i].data);
        OP_NOOUT: begin
          @(negedge clk);
          check($sformatf("vec%0d_out_empty", i), 8'(out_valid), 8'h00);
          @(posedge clk); #1;
        end
        OP_INFULL: begin
          @(negedge clk);
          check($sformatf("vec%0d_in_full", i), 8'(in_ready), 8'h00);
          @(posedge clk); #1;
        end
        default: ;
      endcase
    end

    // Underflow, with out-FIFO filled so STATUS shows only the sticky bit
    for (int i = 0; i < 4; i++) bus_write(A_DATA, 8'(8'hB0 + i), 1'b0);
    bus_read(A_DATA, 1'b0, 8'h00, rd, waits);
    check("unf_data", rd, 8'h00);
    check("unf_in_ready", 8'(in_ready), 8'h01);
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("unf_status", rd, 8'h08);

    // Write to full out-FIFO while out_ready pops on the same edge
    bus_write(A_DATA, 8'hCC, 1'b1);
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("drop_status", rd, 8'h0E);
    take_out(8'hB1);
    take_out(8'hB2);
    take_out(8'hB3);
    @(negedge clk);
    check("drop_no_cc", 8'(out_valid), 8'h00);
    @(posedge clk); #1;
    bus_write(A_STAT, 8'h5F, 1'b0);
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("clear_status", rd, 8'h02);

    // Wait states on a selected access, none outside the window
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("ws_count", 8'(waits), 8'(WS));
    check("ws_data", rd, 8'h02);
    for (int k = 0; k < 2; k++) begin
      a    = (k == 0) ? 16'h1000 : 16'hC002;
      n_oe = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check($sformatf("unsel%0d_n_rdy", k), 8'(n_rdy), 8'h00);
        check($sformatf("unsel%0d_d_hiz", k), d, 8'hFF);
      end
      @(posedge clk); #1;
      n_oe = 1'b1;
      @(posedge clk); #1;
    end

    // Pointer wrap: 20 bytes through the out-FIFO, order preserved
    for (int i = 0; i < 10; i++) begin
      bus_write(A_DATA, 8'(8'h40 + 2 * i), 1'b0);
      check("wrap_out_valid_latency", 8'(out_valid), 8'h01);
      bus_write(A_DATA, 8'(8'h41 + 2 * i), 1'b0);
      take_out(8'(8'h40 + 2 * i));
      take_out(8'(8'h41 + 2 * i));
    end
    @(negedge clk);
    check("wrap_drained", 8'(out_valid), 8'h00);
    @(posedge clk); #1;

    // Stream push and bus pop on the same edge with two entries
    push_in(8'h61);
    push_in(8'h62);
    bus_read(A_DATA, 1'b1, 8'h63, rd, waits);
    check("simul_rd", rd, 8'h61);
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("simul_status", rd, 8'h03);
    bus_read(A_DATA, 1'b0, 8'h00, rd, waits);
    check("simul_rd2", rd, 8'h62);
    bus_read(A_DATA, 1'b0, 8'h00, rd, waits);
    check("simul_rd3", rd, 8'h63);
    bus_read(A_STAT, 1'b0, 8'h00, rd, waits);
    check("simul_empty", rd, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
